dds_mfsk_mod: RTL and testbench

//  Parametrised M-FSK/OOK direct digital synthesiser: the next-generation DDS core with a generic accumulator/DAC width.

---
 rtl/dds_mfsk_mod.sv | 159 +++++++++++++++
 tb/tb_dds_mfsk_mod.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_mfsk_mod.sv
// M-FSK/OOK direct digital synthesiser with phase-continuous tone switching and a 2-stage quarter-wave sine pipeline.
// Optional PHASE_MOD_EN adds a per-symbol phase offset input (ph_off) applied only to the lookup phase.
module dds_mfsk_mod #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int DAC_W  = 8,
  parameter int SYM_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SYM_W-1:0] cfg_addr,
  input  logic [ACC_W-1:0] cfg_data,
  input  logic [SYM_W-1:0] sym,
  input  logic             sym_valid,
  input  logic             enable,
  input  logic             phase_clr,
`ifdef PHASE_MOD_EN
  input  logic [SYM_W-1:0] ph_off,
`endif
  output logic [DAC_W-1:0] dac_out,
  output logic             dac_valid,
  output logic             wrap
);

  localparam int NWORDS  = 2 ** SYM_W;
  localparam int QW      = LUT_AW - 2;
  localparam int QN      = 2 ** QW;
  localparam int MID_I   = 2 ** (DAC_W - 1);
  localparam int MIDM1_I = MID_I - 1;
  localparam logic [DAC_W-1:0] MID    = MID_I[DAC_W-1:0];
  localparam logic [DAC_W-1:0] MID_M1 = MIDM1_I[DAC_W-1:0];
  localparam real PI = 3.14159265358979323846;

  // Quarter-wave table is sampled at bin centres so the fold needs no end-point correction.
  function automatic logic [DAC_W-2:0] sineEntry(input int a);
    real amp;
    real ang;
    int  r;
    amp = real'(MIDM1_I);
    ang = PI / 2.0 * (real'(a) + 0.5) / real'(QN);
    r   = $rtoi(amp * $sin(ang) + 0.5);
    return r[DAC_W-2:0];
  endfunction

  logic [DAC_W-2:0] sineRom [QN];

  for (genvar g = 0; g < QN; g++) begin : gRom
    localparam logic [DAC_W-2:0] ENTRY = sineEntry(g);
    assign sineRom[g] = ENTRY;
  end

  logic [ACC_W-1:0] freqQ [NWORDS];
  logic [SYM_W-1:0] symQ;
  logic [ACC_W-1:0] accQ, accD;
  logic             wrapQ, wrapD;
  logic             cfgReadyQ;
  logic [QW-1:0]    addrQ, addrD;
  logic             negQ, ookQ, v1Q;
  logic [DAC_W-1:0] dacQ, dacD;
  logic             dacValidQ;
  logic [SYM_W-1:0] phOff;

  logic [ACC_W-1:0]  word;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  phase;
  logic [LUT_AW-1:0] p;
  logic [1:0]        quad;
  logic [QW-1:0]     idx;
  logic              cfgAccept;

`ifdef PHASE_MOD_EN
  logic [SYM_W-1:0] phOffQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phOffQ <= '0;
    end else if (sym_valid) begin
      phOffQ <= ph_off;
    end
  end

  assign phOff = phOffQ;
`else
  assign phOff = '0;
`endif

  assign cfgAccept = cfg_valid && cfgReadyQ;
  assign word      = freqQ[symQ];

  always_comb begin
    sum   = {1'b0, accQ} + {1'b0, word};
    accD  = accQ;
    wrapD = 1'b0;
    if (phase_clr) begin
      accD = '0;
    end else if (enable && (word != '0)) begin
      accD  = sum[ACC_W-1:0];
      wrapD = sum[ACC_W];
    end

    // The phase offset only shifts the lookup; it never enters the accumulator.
    phase = accQ + {phOff, {(ACC_W-SYM_W){1'b0}}};
    p     = phase[ACC_W-1 -: LUT_AW];
    quad  = p[LUT_AW-1:LUT_AW-2];
    idx   = p[QW-1:0];
    addrD = quad[0] ? ~idx : idx;

    if (ookQ) begin
      dacD = MID;
    end else if (negQ) begin
      dacD = MID_M1 - {1'b0, sineRom[addrQ]};
    end else begin
      dacD = MID + {1'b0, sineRom[addrQ]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NWORDS; k++) freqQ[k] <= '0;
      cfgReadyQ <= 1'b1;
      symQ      <= '0;
      accQ      <= '0;
      wrapQ     <= 1'b0;
    end else begin
      if (cfgAccept) freqQ[cfg_addr] <= cfg_data;
      cfgReadyQ <= !cfgAccept;
      if (sym_valid) symQ <= sym;
      accQ  <= accD;
      wrapQ <= wrapD;
    end
  end

  // S1 holds the folded address, S2 the mirrored sample, so dac_out trails acc by two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ     <= '0;
      negQ      <= 1'b0;
      ookQ      <= 1'b1;
      v1Q       <= 1'b0;
      dacQ      <= MID;
      dacValidQ <= 1'b0;
    end else begin
      addrQ     <= addrD;
      negQ      <= quad[1];
      ookQ      <= (word == '0);
      v1Q       <= v1Q | enable;
      dacQ      <= dacD;
      dacValidQ <= v1Q;
    end
  end

  assign cfg_ready = cfgReadyQ;
  assign dac_out   = dacQ;
  assign dac_valid = dacValidQ;
  assign wrap      = wrapQ;

endmodule

// File: tb/tb_dds_mfsk_mod.sv
// Self-checking bench for dds_mfsk_mod: a spec-level tone model checked every cycle plus directed literal checks.
// Define PHASE_MOD_EN for both files to exercise the phase-offset input.
module tb_dds_mfsk_mod;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfgValid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfgAddr = '0;
  logic [23:0] cfgData = '0;
  logic [1:0]  symIn = '0;
  logic        symValid = 1'b0;
  logic        enable = 1'b0;
  logic        phaseClr = 1'b0;
  logic [1:0]  phOff = '0;
  logic [7:0]  dac_out;
  logic        dac_valid;
  logic        wrap;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk = ~clk;

  dds_mfsk_mod dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfgValid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfgAddr),
    .cfg_data  (cfgData),
    .sym       (symIn),
    .sym_valid (symValid),
    .enable    (enable),
    .phase_clr (phaseClr),
`ifdef PHASE_MOD_EN
    .ph_off    (phOff),
`endif
    .dac_out   (dac_out),
    .dac_valid (dac_valid),
    .wrap      (wrap)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sine sample for a full 24-bit phase: quadrant mirror of a centre-sampled quarter wave.
  function automatic int sampleOf(input int unsigned ph);
    int p, q, i, a, s;
    p = (ph >> 16) & 255;
    q = p / 64;
    i = p % 64;
    a = (q % 2 == 1) ? 63 - i : i;
    s = $rtoi(127.0 * $sin(PI / 2.0 * (real'(a) + 0.5) / 64.0) + 0.5);
    return (q < 2) ? 128 + s : 127 - s;
  endfunction

  int unsigned mWords [4] = '{0, 0, 0, 0};
  int unsigned mAcc   = 0;
  int          mSym   = 0;
  int          mOff   = 0;
  int          mReady = 1;
  int          mWrap  = 0;
  int          mV1    = 0;
  int          mValid = 0;
  int          mS1    = 128;
  int          mDac   = 128;

  // Model advances on the same edges as the DUT, working from the spec rules with plain arithmetic.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mWords = '{0, 0, 0, 0};
      mAcc = 0; mSym = 0; mOff = 0; mReady = 1; mWrap = 0;
      mV1 = 0; mValid = 0; mS1 = 128; mDac = 128;
    end else begin
      int unsigned w;
      longint nxt;
      w      = mWords[mSym];
      mDac   = mS1;
      mS1    = (w == 0) ? 128 : sampleOf(mAcc + (int'(mOff) << 22));
      mValid = mV1;
      mV1    = mV1 | int'(enable);
      mWrap  = 0;
      if (phaseClr) begin
        mAcc = 0;
      end else if (enable && w != 0) begin
        nxt   = longint'(mAcc) + longint'(w);
        mWrap = (nxt >= 64'h1000000) ? 1 : 0;
        mAcc  = int'(nxt % 64'h1000000);
      end
      if (cfgValid && mReady == 1) mWords[cfgAddr] = cfgData;
      mReady = (cfgValid && mReady == 1) ? 0 : 1;
      if (symValid) begin
        mSym = symIn;
        mOff = phOff;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("dac_out", dac_out, mDac);
    checkOutput("dac_valid", dac_valid, mValid);
    checkOutput("wrap", wrap, mWrap);
    checkOutput("cfg_ready", cfg_ready, mReady);
  end

  task automatic applyStimulus(input logic cv, input logic [1:0] ca, input logic [23:0] cd,
                               input logic sv, input logic [1:0] s, input logic en,
                               input logic pc, input int cycles);
    cfgValid = cv; cfgAddr = ca; cfgData = cd;
    symValid = sv; symIn = s; enable = en; phaseClr = pc;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int wraps, firstWrap, lastWrap, maxDac, minDac, accepted, held;

    checkOutput("model_p0", sampleOf(32'h000000), 8'h82);
    checkOutput("model_p64", sampleOf(32'h400000), 8'hFF);
    checkOutput("model_p128", sampleOf(32'h800000), 8'h7D);
    checkOutput("model_p192", sampleOf(32'hC00000), 8'h00);

    repeat (3) @(negedge clk);
    checkOutput("rst_dac", dac_out, 8'h80);
    checkOutput("rst_valid", dac_valid, 0);
    checkOutput("rst_ready", cfg_ready, 1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 3);
    checkOutput("first_sample", dac_out, 8'h80);
    checkOutput("first_valid", dac_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    applyStimulus(1, 0, 24'h010000, 0, 0, 0, 0, 1);
    checkOutput("ready_low", cfg_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ready_back", cfg_ready, 1);

    // Single tone: one LUT step per cycle.
    wraps = 0; firstWrap = -1; lastWrap = -1; maxDac = 0; minDac = 255;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        if (firstWrap < 0) firstWrap = i;
        lastWrap = i;
      end
      if (dac_out > maxDac) maxDac = dac_out;
      if (dac_out < minDac) minDac = dac_out;
    end
    checkOutput("tone_wraps", wraps, 2);
    checkOutput("tone_period", lastWrap - firstWrap, 256);
    checkOutput("tone_max", maxDac, 8'hFF);
    checkOutput("tone_min", minDac, 8'h00);

    // FSK switch to a double-rate word.
    applyStimulus(1, 1, 24'h020000, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    wraps = 0; firstWrap = -1; lastWrap = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        if (firstWrap < 0) firstWrap = i;
        lastWrap = i;
      end
    end
    checkOutput("fsk_wraps", wraps, 2);
    checkOutput("fsk_period", lastWrap - firstWrap, 128);

    // OOK via the zero word, then resume.
    applyStimulus(0, 0, 0, 1, 2, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 10);
    checkOutput("ook_dac", dac_out, 8'h80);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 5);
    checkOutput("ook_steady", dac_out, 8'h80);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 20);

    accepted = 0;
    applyStimulus(1, 3, 24'h000100, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (cfg_ready) accepted++;
      @(negedge clk);
    end
    checkOutput("b2b_accepts", accepted, 3);

    applyStimulus(1, 3, 24'h030000, 1, 3, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 40);

    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("clr_no_wrap", wrap, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
    checkOutput("clr_dac", dac_out, 8'h82);
    held = dac_out;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
    checkOutput("hold_dac", dac_out, held);

    // Asynchronous reset in the middle of a tone.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 30);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_dac", dac_out, 8'h80);
    checkOutput("arst_valid", dac_valid, 0);
    checkOutput("arst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 20);
    checkOutput("arst_words_zero", dac_out, 8'h80);

`ifdef PHASE_MOD_EN
    applyStimulus(1, 0, 24'h010000, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 37);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
    held = dac_out;
    phOff = 2'd2;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
    checkOutput("phmod_180", dac_out, 255 - held);
    phOff = 2'd0;
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
